// File: rtl/intr_sched.sv
// intr_sched: three-bus interrupt scheduler with per-channel enables, a
// non-preemptive grant/ack handshake, a grant timeout and a sticky fault mask.
//
// Ports:
//   clk          single clock, all state on the rising edge
//   rst          synchronous, active-high reset
//   irq_a/b/c    level requests, bus A highest priority, bus C lowest
//   en           per-channel enable shared by all three buses
//   ack          requester acknowledge of the current grant
//   fclr         clears the whole fault mask
//   grant_valid  a grant is being offered
//   grant_bus    bus of the granted channel (0=A, 1=B, 2=C)
//   grant_ch     channel index of the grant
//   busy         FSM is not idle
//   timeout_err  one-cycle pulse when a grant expires without ack
//   fault        at least one fault-mask bit is set
module intr_sched #(
  parameter int unsigned NCH     = 9,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] irq_a,
  input  logic [NCH-1:0] irq_b,
  input  logic [NCH-1:0] irq_c,
  input  logic [NCH-1:0] en,
  input  logic           ack,
  input  logic           fclr,
  output logic           grant_valid,
  output logic [1:0]     grant_bus,
  output logic [3:0]     grant_ch,
  output logic           busy,
  output logic           timeout_err,
  output logic           fault
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  logic [1:0]            r_state;
  logic [2:0][NCH-1:0]   r_pend;
  logic [2:0][NCH-1:0]   r_fmask;
  logic [7:0]            r_timer;
  logic [1:0]            r_bus;
  logic [3:0]            r_ch;
  logic                  r_tmo;

  logic [2:0][NCH-1:0]   w_irq;
  logic [2:0][NCH-1:0]   w_set;
  logic [2:0][NCH-1:0]   w_elig;
  logic [2:0][NCH-1:0]   w_gmask;
  logic [2:0][NCH-1:0]   w_clr;
  logic [2:0][NCH-1:0]   w_fset;
  logic                  w_any;
  logic [1:0]            w_bus;
  logic [3:0]            w_ch;
  logic                  w_timeout;
  logic                  w_done;

  // Index 0 is bus A so that the scan below visits buses in priority order.
  always_comb begin
    w_irq = {irq_c, irq_b, irq_a};
    for (int unsigned b = 0; b < 3; b++) begin
      w_set[b]  = w_irq[b] & en;
      w_elig[b] = r_pend[b] & ~r_fmask[b] & en;
    end
  end

  // First eligible bit in (bus, channel) ascending order wins.
  always_comb begin
    w_any = 1'b0;
    w_bus = '0;
    w_ch  = '0;
    for (int unsigned b = 0; b < 3; b++) begin
      for (int unsigned c = 0; c < NCH; c++) begin
        if (!w_any && w_elig[b][c]) begin
          w_any = 1'b1;
          w_bus = 2'(b);
          w_ch  = 4'(c);
        end
      end
    end
  end

  // One-hot mask of the currently latched grant.
  always_comb begin
    for (int unsigned b = 0; b < 3; b++) begin
      for (int unsigned c = 0; c < NCH; c++) begin
        w_gmask[b][c] = (r_bus == 2'(b)) && (r_ch == 4'(c));
      end
    end
  end

  always_comb begin
    w_timeout = (r_state == S_GRANT) && !ack && (r_timer == TMO_LAST);
    w_done    = (r_state == S_DONE);
    w_clr     = w_done    ? w_gmask : '0;
    w_fset    = w_timeout ? w_gmask : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pend  <= '0;
      r_fmask <= '0;
      r_timer <= '0;
      r_bus   <= '0;
      r_ch    <= '0;
      r_tmo   <= 1'b0;
    end else begin
      // Clear is applied after set so a DONE clear wins over a same-cycle set.
      r_pend  <= (r_pend | w_set) & ~w_clr;
      // A new fault bit survives a simultaneous fclr.
      r_fmask <= (fclr ? '0 : r_fmask) | w_fset;
      r_tmo   <= w_timeout;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_bus   <= w_bus;
            r_ch    <= w_ch;
            r_timer <= '0;
            r_state <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (ack) begin
            r_state <= S_DONE;
          end else if (w_timeout) begin
            r_state <= S_IDLE;
          end else begin
            r_timer <= r_timer + 8'd1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign grant_valid = (r_state == S_GRANT);
  assign busy        = (r_state != S_IDLE);
  assign grant_bus   = r_bus;
  assign grant_ch    = r_ch;
  assign timeout_err = r_tmo;
  assign fault       = |r_fmask;

endmodule
